// File: rtl/rv32i_exec_stage.sv
// Purpose : RV32I OP/OP-IMM execute/writeback sequencer with an internal 32x32 register file.
// Latency : accept at edge T0, writeback visible T1..T2, register file updated at T2.
// Backpressure: one instruction in flight; o_ready is high only in IDLE (one accept per 3 cycles).
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_instr, i_valid, o_ready instruction handshake (accept when i_valid & o_ready)
//   o_alu_a/b/op, i_alu_result  registered external ALU interface (result one cycle after sampling)
//   o_wb_valid/rd/data        writeback pulse and payload
//   o_illegal                 one-cycle pulse for a rejected instruction
//   i_dbg_raddr, o_dbg_rdata  combinational debug register read (x0 reads 0)
// Optional feature macro: ALU_SUB_EN (makes OP SUB legal, implemented as ADD of -rs2).
module rv32i_exec_stage #(
    parameter int unsigned RESET_REGS = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_instr,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [31:0] o_alu_a,
    output logic [31:0] o_alu_b,
    output logic [2:0]  o_alu_op,
    input  logic [31:0] i_alu_result,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_illegal,
    input  logic [4:0]  i_dbg_raddr,
    output logic [31:0] o_dbg_rdata
);

    typedef enum logic [1:0] {IDLE, EXEC, WB, ERR} state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    state_t      state_q;
    logic        rdy_q;
    logic        wb_vld_q;
    logic        ill_q;
    logic [31:0] alu_a_q;
    logic [31:0] alu_b_q;
    logic [2:0]  alu_op_q;
    logic [4:0]  rd_q;

    logic [31:0] rf [32];

    // Instruction fields
    logic [6:0]  opcode;
    logic [4:0]  rd_f;
    logic [2:0]  funct3;
    logic [4:0]  rs1_f;
    logic [4:0]  rs2_f;
    logic [6:0]  funct7;
    logic [31:0] imm_sext;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    assign opcode   = i_instr[6:0];
    assign rd_f     = i_instr[11:7];
    assign funct3   = i_instr[14:12];
    assign rs1_f    = i_instr[19:15];
    assign rs2_f    = i_instr[24:20];
    assign funct7   = i_instr[31:25];
    assign imm_sext = {{20{i_instr[31]}}, i_instr[31:20]};

    // x0 is hard-wired to zero at every read port, so rf[0] content never matters.
    assign rs1_val     = (rs1_f == 5'd0)       ? 32'd0 : rf[rs1_f];
    assign rs2_val     = (rs2_f == 5'd0)       ? 32'd0 : rf[rs2_f];
    assign o_dbg_rdata = (i_dbg_raddr == 5'd0) ? 32'd0 : rf[i_dbg_raddr];

    // Decode: legality and the operand B value loaded at accept.
    logic        legal;
    logic [31:0] alu_b_d;

    always_comb begin
        legal   = 1'b0;
        alu_b_d = (opcode == OPC_OP) ? rs2_val : imm_sext;
        if (opcode == OPC_OP) begin
            if (funct3 != 3'b001) begin
                if (funct7 == 7'b0000000) begin
                    legal = 1'b1;
                end
`ifdef ALU_SUB_EN
                else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    // SUB runs on the ADD path with a two's-complement negated rs2.
                    legal   = 1'b1;
                    alu_b_d = ~rs2_val + 32'd1;
                end
`endif
            end
        end else if (opcode == OPC_OP_IMM) begin
            if (funct3 == 3'b101) begin
                // Only SRLI is supported: imm[11:5] must be clear (rejects SRAI too).
                legal = (funct7 == 7'b0000000);
            end else begin
                legal = (funct3 != 3'b001);
            end
        end
        // Shift amount is the low 5 bits only.
        if (funct3 == 3'b101) begin
            alu_b_d = {27'd0, alu_b_d[4:0]};
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            rdy_q    <= 1'b1;
            wb_vld_q <= 1'b0;
            ill_q    <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            rd_q     <= '0;
        end else begin
            wb_vld_q <= 1'b0;
            ill_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        rdy_q <= 1'b0;
                        if (legal) begin
                            alu_a_q  <= rs1_val;
                            alu_b_q  <= alu_b_d;
                            alu_op_q <= funct3;
                            rd_q     <= rd_f;
                            state_q  <= EXEC;
                        end else begin
                            ill_q   <= 1'b1;
                            state_q <= ERR;
                        end
                    end
                end
                EXEC: begin
                    // ALU samples the held operands at the end of this cycle.
                    wb_vld_q <= 1'b1;
                    state_q  <= WB;
                end
                WB: begin
                    rdy_q   <= 1'b1;
                    state_q <= IDLE;
                end
                ERR: begin
                    rdy_q   <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    rdy_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Register file: write at the end of WB; reset takes priority so an abandoned
    // instruction never commits.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            if (RESET_REGS != 0) begin
                for (int i = 0; i < 32; i++) begin
                    rf[i] <= '0;
                end
            end
        end else if (state_q == WB && rd_q != 5'd0) begin
            rf[rd_q] <= i_alu_result;
        end
    end

    assign o_ready    = rdy_q;
    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_wb_valid = wb_vld_q;
    assign o_wb_rd    = rd_q;
    assign o_wb_data  = wb_vld_q ? i_alu_result : 32'd0;
    assign o_illegal  = ill_q;

endmodule

// File: tb/tb_rv32i_exec_stage.sv
// Purpose : directed-vector bench for rv32i_exec_stage with a behavioural registered ALU.
// Latency : inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: every instruction is issued only when o_ready is high.
module tb_rv32i_exec_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        vld;
    logic        rdy;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_res;
    logic        wb_vld;
    logic [4:0]  wb_rd;
    logic [31:0] wb_dat;
    logic        illegal;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_dat;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    rv32i_exec_stage #(.RESET_REGS(1)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_instr      (instr),
        .i_valid      (vld),
        .o_ready      (rdy),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_op     (alu_op),
        .i_alu_result (alu_res),
        .o_wb_valid   (wb_vld),
        .o_wb_rd      (wb_rd),
        .o_wb_data    (wb_dat),
        .o_illegal    (illegal),
        .i_dbg_raddr  (dbg_addr),
        .o_dbg_rdata  (dbg_dat)
    );

    // Downstream single-cycle registered ALU.
    always @(posedge clk) begin
        case (alu_op)
            3'b000:  alu_res <= alu_a + alu_b;
            3'b010:  alu_res <= {31'd0, $signed(alu_a) < $signed(alu_b)};
            3'b011:  alu_res <= {31'd0, alu_a < alu_b};
            3'b100:  alu_res <= alu_a ^ alu_b;
            3'b101:  alu_res <= alu_a >> alu_b[4:0];
            3'b110:  alu_res <= alu_a | alu_b;
            3'b111:  alu_res <= alu_a & alu_b;
            default: alu_res <= 32'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Legal instruction: accept, EXEC, WB, back to IDLE.
    task automatic run_instr(input string tag, input logic [31:0] ins,
                             input logic [31:0] ea, input logic [31:0] eb,
                             input logic [2:0] eop, input logic [4:0] erd,
                             input logic [31:0] edat, input logic [31:0] eold);
        chk({tag, ".rdy_idle"}, {31'd0, rdy}, 32'd1);
        vld      = 1'b1;
        instr    = ins;
        dbg_addr = erd;
        step();                                   // accept edge T0 -> EXEC
        vld   = 1'b0;
        instr = 32'd0;
        chk({tag, ".rdy_exec"}, {31'd0, rdy}, 32'd0);
        chk({tag, ".alu_a"}, alu_a, ea);
        chk({tag, ".alu_b"}, alu_b, eb);
        chk({tag, ".alu_op"}, {29'd0, alu_op}, {29'd0, eop});
        chk({tag, ".wbv_exec"}, {31'd0, wb_vld}, 32'd0);
        step();                                   // T1 -> WB
        chk({tag, ".wbv"}, {31'd0, wb_vld}, 32'd1);
        chk({tag, ".wb_rd"}, {27'd0, wb_rd}, {27'd0, erd});
        chk({tag, ".wb_dat"}, wb_dat, edat);
        chk({tag, ".rdy_wb"}, {31'd0, rdy}, 32'd0);
        chk({tag, ".dbg_old"}, dbg_dat, eold);
        step();                                   // T2 -> IDLE, register written
        chk({tag, ".wbv_end"}, {31'd0, wb_vld}, 32'd0);
        chk({tag, ".rdy_end"}, {31'd0, rdy}, 32'd1);
        chk({tag, ".dbg_new"}, dbg_dat, (erd == 5'd0) ? 32'd0 : edat);
        chk({tag, ".alu_b_hold"}, alu_b, eb);
    endtask

    // Rejected instruction: one ERR cycle with o_illegal, no writeback.
    task automatic run_illegal(input string tag, input logic [31:0] ins,
                               input logic [4:0] erd, input logic [31:0] eold);
        chk({tag, ".rdy_idle"}, {31'd0, rdy}, 32'd1);
        vld      = 1'b1;
        instr    = ins;
        dbg_addr = erd;
        step();
        vld   = 1'b0;
        instr = 32'd0;
        chk({tag, ".ill"}, {31'd0, illegal}, 32'd1);
        chk({tag, ".rdy_err"}, {31'd0, rdy}, 32'd0);
        chk({tag, ".wbv_err"}, {31'd0, wb_vld}, 32'd0);
        step();
        chk({tag, ".ill_end"}, {31'd0, illegal}, 32'd0);
        chk({tag, ".rdy_end"}, {31'd0, rdy}, 32'd1);
        chk({tag, ".wbv_end"}, {31'd0, wb_vld}, 32'd0);
        chk({tag, ".dbg"}, dbg_dat, eold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        vld      = 1'b0;
        instr    = 32'd0;
        dbg_addr = 5'd0;
        do_reset();

        // Reset state
        dbg_addr = 5'd1;
        #1;
        chk("rst.rdy",    {31'd0, rdy},     32'd1);
        chk("rst.alu_a",  alu_a,            32'd0);
        chk("rst.alu_b",  alu_b,            32'd0);
        chk("rst.alu_op", {29'd0, alu_op},  32'd0);
        chk("rst.wb_rd",  {27'd0, wb_rd},   32'd0);
        chk("rst.wb_dat", wb_dat,           32'd0);
        chk("rst.wbv",    {31'd0, wb_vld},  32'd0);
        chk("rst.ill",    {31'd0, illegal}, 32'd0);
        chk("rst.x1",     dbg_dat,          32'd0);

        // ADDI x1,x0,5 ; ADDI x2,x0,-3 ; SLT x3,x2,x1
        run_instr("addi_x1", 32'h00500093, 32'd0, 32'd5, 3'b000, 5'd1, 32'd5, 32'd0);
        run_instr("addi_x2", 32'hFFD00113, 32'd0, 32'hFFFFFFFD, 3'b000, 5'd2, 32'hFFFFFFFD, 32'd0);
        run_instr("slt_x3",  32'h001121B3, 32'hFFFFFFFD, 32'd5, 3'b010, 5'd3, 32'd1, 32'd0);

        // SUB x4,x1,x2
`ifdef ALU_SUB_EN
        run_instr("sub_x4", 32'h40208233, 32'd5, 32'd3, 3'b000, 5'd4, 32'd8, 32'd0);
`else
        run_illegal("sub_x4", 32'h40208233, 5'd4, 32'd0);
`endif

        // SLL x5,x1,x1 is never supported
        run_illegal("sll_x5", 32'h001092B3, 5'd5, 32'd0);
        // SRAI x9,x1,1 and a load opcode are rejected
        run_illegal("srai_x9", 32'h4010D493, 5'd9, 32'd0);
        run_illegal("load",    32'h00000003, 5'd0, 32'd0);

        // Reset clears the register file
        do_reset();
        dbg_addr = 5'd1;
        #1;
        chk("rst2.x1", dbg_dat, 32'd0);

        // Shift cases
        run_instr("addi_x1b", 32'h00500093, 32'd0, 32'd5, 3'b000, 5'd1, 32'd5, 32'd0);
        run_instr("addi_x6",  32'h02100313, 32'd0, 32'h21, 3'b000, 5'd6, 32'h21, 32'd0);
        run_instr("srl_x7",   32'h0060D3B3, 32'd5, 32'd1, 3'b101, 5'd7, 32'd2, 32'd0);
        run_instr("srli_x9",  32'h0020D493, 32'd5, 32'd2, 3'b101, 5'd9, 32'd1, 32'd0);

        // Other ALU ops
        run_instr("addi_x2b", 32'hFFD00113, 32'd0, 32'hFFFFFFFD, 3'b000, 5'd2, 32'hFFFFFFFD, 32'd0);
        run_instr("sltu_x10", 32'h00113533, 32'hFFFFFFFD, 32'd5, 3'b011, 5'd10, 32'd0, 32'd0);
        run_instr("andi_x11", 32'h0F017593, 32'hFFFFFFFD, 32'h0F0, 3'b111, 5'd11, 32'h0F0, 32'd0);
        run_instr("xori_x12", 32'hFFF0C613, 32'd5, 32'hFFFFFFFF, 3'b100, 5'd12, 32'hFFFFFFFA, 32'd0);
        // Overwrite an existing register: old value visible during WB
        run_instr("addi_x1c", 32'h00700093, 32'd0, 32'd7, 3'b000, 5'd1, 32'd7, 32'd5);

        // ADDI x8,x0,7 abandoned by reset during EXEC
        vld      = 1'b1;
        instr    = 32'h00700413;
        dbg_addr = 5'd8;
        step();
        vld   = 1'b0;
        instr = 32'd0;
        rst   = 1'b1;
        step();
        rst = 1'b0;
        chk("abort.wbv", {31'd0, wb_vld}, 32'd0);
        chk("abort.rdy", {31'd0, rdy},    32'd1);
        step();
        chk("abort.wbv2", {31'd0, wb_vld}, 32'd0);
        chk("abort.x8",   dbg_dat,         32'd0);

        // ADDI x0,x0,9: writeback pulses, x0 stays zero
        run_instr("addi_x0", 32'h00900013, 32'd0, 32'd9, 3'b000, 5'd0, 32'd9, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
